// File: rtl/hood_display_scan.sv
// Multiplexed 8-tube hood display scanner with valid/ready frame update; optional blink via HOOD_DISPLAY_BLINK_EN.
// Latency: outputs register on each scan tick; an accepted frame goes live on the next idx 3->0 wrap tick.
// Backpressure: upd_ready drops after an accept and returns when the pending frame is applied; offers meanwhile are ignored.
module hood_display_scan #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [2:0]  upd_mode,
  input  logic [15:0] upd_value,
  input  logic        upd_blink,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef struct packed {
    logic [2:0]  mode;
    logic [15:0] value;
    logic        blink;
  } frame_t;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic             tick;
  logic             wrap;
  logic             accept;
  logic             pend_vld_q;
  frame_t           pend_q;
  frame_t           act_q;
  frame_t           act_d;
  frame_t           upd_frame;
  logic             blank_blink;
  logic [7:0]       hi_glyph;
  logic [7:0]       lo_glyph;
  logic [7:0]       sel_d;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'd0:    g = 8'hFC;
      4'd1:    g = 8'h60;
      4'd2:    g = 8'hDA;
      4'd3:    g = 8'hF2;
      4'd4:    g = 8'h66;
      4'd5:    g = 8'hB6;
      4'd6:    g = 8'hBE;
      4'd7:    g = 8'hE0;
      4'd8:    g = 8'hFE;
      4'd9:    g = 8'hF6;
      default: g = 8'h02;  // out-of-range nibble shows a dash
    endcase
    return g;
  endfunction

  // Glyph for tube t of frame f, including leading-zero blanking of d3..d1.
  function automatic logic [7:0] tube_glyph(input frame_t f, input logic [2:0] t);
    logic [3:0] d3, d2, d1, d0;
    logic       z3, z2, z1;
    logic [7:0] g;
    d3 = f.value[15:12];
    d2 = f.value[11:8];
    d1 = f.value[7:4];
    d0 = f.value[3:0];
    z3 = (d3 == 4'd0);
    z2 = z3 && (d2 == 4'd0);
    z1 = z2 && (d1 == 4'd0);
    case (t)
      3'd7:    g = 8'hCE;
      3'd6:    g = (f.mode > 3'd3) ? 8'h02 : seg7({1'b0, f.mode});
      3'd5:    g = 8'h00;
      3'd4:    g = 8'h00;
      3'd3:    g = z3 ? 8'h00 : seg7(d3);
      3'd2:    g = z2 ? 8'h00 : seg7(d2);
      3'd1:    g = z1 ? 8'h00 : seg7(d1);
      default: g = seg7(d0);
    endcase
    return g;
  endfunction

  assign tick      = (div_q == DIV_LAST);
  assign idx_d     = idx_q + 2'd1;
  assign wrap      = tick && (idx_q == 2'd3);
  assign upd_ready = ~pend_vld_q;
  assign accept    = upd_valid && upd_ready;
  // A pending frame is swapped in only at a wrap, so the glyphs of that tick already show it.
  assign act_d     = (wrap && pend_vld_q) ? pend_q : act_q;

`ifdef HOOD_DISPLAY_BLINK_EN
  logic [9:0] blink_cnt_q;
  logic       blink_off_q;
  logic       blink_wrap;
  logic       blink_off_d;

  assign blink_wrap  = tick && (blink_cnt_q == 10'(BLINK_TICKS - 1));
  assign blink_off_d = blink_wrap ? ~blink_off_q : blink_off_q;
  assign upd_frame   = '{mode: upd_mode, value: upd_value, blink: upd_blink};

  // Free-running blink phase, advanced by scan ticks regardless of the frame flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= 10'd0;
      blink_off_q <= 1'b0;
    end else if (tick) begin
      blink_cnt_q <= blink_wrap ? 10'd0 : blink_cnt_q + 10'd1;
      blink_off_q <= blink_off_d;
    end
  end
`else
  logic unused_blink;
  assign upd_frame    = '{mode: upd_mode, value: upd_value, blink: 1'b0};
  assign unused_blink = ^{upd_blink, act_d.blink};
`endif

  // Next-tick outputs, computed from the post-tick index, frame and blink phase.
  always_comb begin
    blank_blink = 1'b0;
`ifdef HOOD_DISPLAY_BLINK_EN
    blank_blink = act_d.blink && blink_off_d;
`endif
    hi_glyph = blank_blink ? 8'h00 : tube_glyph(act_d, {1'b1, idx_d});
    lo_glyph = blank_blink ? 8'h00 : tube_glyph(act_d, {1'b0, idx_d});
    sel_d    = 8'h11 << idx_d;
  end

  // Scan-rate divider; the terminal count cycle is the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Scan index, active frame and registered tube outputs update together on a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= 2'd0;
      act_q    <= '0;
      tube_sel <= 8'h00;
      digit1   <= 8'h00;
      digit2   <= 8'h00;
    end else if (tick) begin
      idx_q    <= idx_d;
      act_q    <= act_d;
      tube_sel <= sel_d;
      digit1   <= hi_glyph;
      digit2   <= lo_glyph;
    end
  end

  // Single-entry pending buffer; an accept on a wrap cycle waits for the following wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else if (accept) begin
      pend_vld_q <= 1'b1;
      pend_q     <= upd_frame;
    end else if (wrap) begin
      pend_vld_q <= 1'b0;
    end
  end

endmodule
